// File: rtl/ring_stop.sv
// ring_stop: one stop of the unidirectional force-writeback ring.
// Local packets queue in an injection FIFO. Ring traffic always has priority
// for the outgoing slot and advances one hop per cycle. Packets addressed to
// this node are ejected toward the local force cache with the dest field
// stripped.
// Optional build macro RING_STOP_STATS_EN adds three saturating 32-bit
// activity counters (stat_injected, stat_ejected, stat_stall_cycles).
module ring_stop #(
  parameter int NUM_CELLS         = 64,
  parameter int NODE_ID           = 0,
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
  parameter int FORCE_DATA_WIDTH  = 3*DATA_WIDTH+PARTICLE_ID_WIDTH,
  parameter int PACKET_WIDTH      = FORCE_DATA_WIDTH+NODE_ID_WIDTH,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PACKET_WIDTH-1:0]     packet_in,
  input  logic                        packet_valid,
  output logic                        ready,
  input  logic                        ring_in_valid,
  input  logic [PACKET_WIDTH-1:0]     ring_in_packet,
  output logic                        ring_out_valid,
  output logic [PACKET_WIDTH-1:0]     ring_out_packet,
  output logic                        data_valid,
  output logic [FORCE_DATA_WIDTH-1:0] data_out,
  output logic                        idle
`ifdef RING_STOP_STATS_EN
  ,
  output logic [31:0]                 stat_injected,
  output logic [31:0]                 stat_ejected,
  output logic [31:0]                 stat_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [NODE_ID_WIDTH-1:0] MY_ID = NODE_ID_WIDTH'(NODE_ID);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  // Injection FIFO storage and bookkeeping.
  logic [PACKET_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W:0]          count;

  logic [PACKET_WIDTH-1:0]  head;
  logic [NODE_ID_WIDTH-1:0] head_dest;
  logic [NODE_ID_WIDTH-1:0] ring_dest;
  logic                     fifo_empty;
  logic                     push;
  logic                     ring_eject;
  logic                     ring_fwd;
  logic                     pop_send;
  logic                     pop_eject;
  logic                     pop;

  assign head       = fifo_mem[rd_ptr];
  assign head_dest  = head[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
  assign ring_dest  = ring_in_packet[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
  assign fifo_empty = (count == '0);
  assign ready      = (count != FULL_COUNT);
  assign push       = packet_valid && ready;
  assign pop        = pop_send || pop_eject;
  assign idle       = fifo_empty && !ring_out_valid;

  // Slot arbitration: ring first, then FIFO head; a self-addressed head
  // waits whenever the ring packet already uses the single ejection port.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    ring_eject = 1'b0;
    ring_fwd   = 1'b0;
    pop_send   = 1'b0;
    pop_eject  = 1'b0;
    if (ring_in_valid) begin
      if (ring_dest == MY_ID) ring_eject = 1'b1;
      else                    ring_fwd   = 1'b1;
    end
    if (!ring_fwd && !fifo_empty) begin
      if (head_dest != MY_ID) pop_send  = 1'b1;
      else if (!ring_eject)   pop_eject = 1'b1;
    end
  end

  // FIFO data array write port.
  // NOTE: the storage array is deliberately not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= packet_in;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count steady.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Registered ring output slot and ejection port; payloads hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_out_valid  <= 1'b0;
      ring_out_packet <= '0;
      data_valid      <= 1'b0;
      data_out        <= '0;
    end else begin
      ring_out_valid <= ring_fwd || pop_send;
      if (ring_fwd)      ring_out_packet <= ring_in_packet;
      else if (pop_send) ring_out_packet <= head;
      data_valid <= ring_eject || pop_eject;
      if (ring_eject)     data_out <= ring_in_packet[FORCE_DATA_WIDTH-1:0];
      else if (pop_eject) data_out <= head[FORCE_DATA_WIDTH-1:0];
    end
  end

`ifdef RING_STOP_STATS_EN
  // Saturating activity counters, aligned with the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_injected     <= '0;
      stat_ejected      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (pop_send && stat_injected != '1)
        stat_injected <= stat_injected + 1'b1;
      if ((ring_eject || pop_eject) && stat_ejected != '1)
        stat_ejected <= stat_ejected + 1'b1;
      if (!fifo_empty && !pop && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

  // An out-of-range destination would circulate forever; flag it on entry.
  a_ring_dest_legal : assert property (@(posedge clk) disable iff (rst)
    ring_in_valid |-> (32'(ring_dest) < NUM_CELLS));
  a_local_dest_legal : assert property (@(posedge clk) disable iff (rst)
    push |-> (32'(packet_in[PACKET_WIDTH-1 -: NODE_ID_WIDTH]) < NUM_CELLS));

endmodule

// File: doc/ring_stop.md
Name: ring_stop

Overview:
- One stop of the force-writeback ring interconnect. One instance per cell; NUM_CELLS instances are chained into a unidirectional ring.
- Accepts destination-tagged force packets from the local PE (after destination mapping) into an injection FIFO.
- Forwards transit packets to the next stop, and ejects packets addressed to this node toward the local force cache.
- Bufferless on the ring path: transit traffic always advances one hop per cycle.

Parameters:
NUM_CELLS, 64, number of ring stops; NODE_ID range 0..NUM_CELLS-1
NODE_ID, 0, this stop's node index
DATA_WIDTH, 32, width of one force component
PARTICLE_ID_WIDTH, 7, particle address width
NODE_ID_WIDTH, $clog2(NUM_CELLS), destination field width
FORCE_DATA_WIDTH, 3*DATA_WIDTH+PARTICLE_ID_WIDTH, payload width {particle_id, fz, fy, fx}
PACKET_WIDTH, FORCE_DATA_WIDTH+NODE_ID_WIDTH, packet = {dest_node[MSBs], payload}
FIFO_DEPTH, 8, injection FIFO entries; power of 2, >=2

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
packet_in  input  PACKET_WIDTH  local packet from destination map
packet_valid  input  1  local packet valid
ready  output  1  injection FIFO can accept (combinational = not full)
ring_in_valid  input  1  packet arriving from previous stop
ring_in_packet  input  PACKET_WIDTH  arriving packet
ring_out_valid  output  1  registered packet to next stop
ring_out_packet  output  PACKET_WIDTH  registered packet to next stop
data_valid  output  1  registered ejection strobe to force cache
data_out  output  FORCE_DATA_WIDTH  ejected payload (dest field stripped)
idle  output  1  FIFO empty and ring_out_valid low

Behaviour:
- Reset: ring_out_valid=0, ring_out_packet=0, data_valid=0, data_out=0, FIFO count=0 (ready=1, idle=1). Reset mid-operation discards FIFO contents and in-flight ring_out without error.
- Injection: write when packet_valid & ready. ready = (count != FIFO_DEPTH). A packet offered while full is not written; the PE holds it. An entry written in cycle N is poppable in cycle N+1 at the earliest. Push and pop in the same cycle leave count unchanged.
- Per-cycle decision (ring has strict priority), all outputs registered:
  1. If ring_in_valid and dest==NODE_ID: eject ring packet (data_valid<=1, data_out<=payload). The outgoing ring slot is free.
  2. Else if ring_in_valid: forward it (ring_out<=ring_in). Slot busy.
  3. If slot free and FIFO non-empty, check head dest:
     - dest!=NODE_ID: pop and send to ring_out.
     - dest==NODE_ID (self-addressed): pop and eject locally, only if case 1 did not eject this cycle; otherwise the head waits.
  4. Otherwise ring_out_valid<=0. data_valid<=0 when nothing ejects.
- Latency: injection to ring_out is 1 cycle after the pop decision. Each hop is 1 cycle. Ejection to data_valid is 1 cycle.
- Ordering: FIFO order is preserved per source. There is no head-of-line bypass.
- Starvation: local injection may stall while transit traffic fills the slot. This is bounded because ring occupancy is at most NUM_CELLS packets and no new injections happen upstream once PEs finish. This is accepted behaviour.
- Dest field >= NUM_CELLS is illegal. Such a packet circulates and is never ejected; a simulation assertion flags it.
- idle is combinational from registered state. The top-level drain logic ANDs idle across all stops.

Optional Feature:
RING_STOP_STATS_EN:
- Defined: adds outputs stat_injected, stat_ejected and stat_stall_cycles, each 32 bits.
  - stat_injected increments per FIFO pop sent to the ring.
  - stat_ejected increments per data_valid.
  - stat_stall_cycles increments on each cycle with FIFO non-empty and no pop.
  - All counters clear on rst and saturate at all-ones.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Injection: NUM_CELLS=4, NODE_ID=1, idle ring. Inject dest=3, payload 0x55. Then ring_out_valid=1 next cycle with the same packet; data_valid stays 0; idle returns to 1.
- Ring ejection: ring_in dest=1, payload 0xABC, valid one cycle. Then data_valid=1 with data_out=0xABC one cycle later; ring_out_valid=0.
- Ring priority: FIFO holds dest=2 while ring_in carries dest=0 continuously for 5 cycles. Then FIFO not popped for 5 cycles, and the pop happens on the first cycle with ring_in_valid=0. With RING_STOP_STATS_EN, stat_stall_cycles=5.
- Slot reuse on ejection: ring_in dest=1 arrives while FIFO head dest=3. Then, in the same next cycle, data_valid=1 (ring payload) and ring_out carries the FIFO head.
- Self-addressed conflict: FIFO head dest=1 and ring_in dest=1 in the same cycle. Then the ring packet ejects first and the head ejects the following cycle; no loss or duplication.
- Full and reset: push 8 packets with the ring saturated. Then ready=0 after the 8th push and a 9th offer is not written. Assert rst mid-burst: all outputs are 0, ready=1 and idle=1 on the next cycle.
